// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch and the LSU.
// Data wins by default; a saturating starvation counter lets fetch through after StarveLimit data grants.
module mem_port_arbiter #(
   parameter int Width       = 32,
   parameter int StarveLimit = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             if_req_i,
   input  logic [Width-1:0] if_addr_i,
   output logic             if_gnt_o,
   output logic             if_rvalid_o,
   output logic [Width-1:0] if_rdata_o,
   input  logic             d_req_i,
   input  logic             d_we_i,
   input  logic [3:0]       d_be_i,
   input  logic [Width-1:0] d_addr_i,
   input  logic [Width-1:0] d_wdata_i,
   output logic             d_gnt_o,
   output logic             d_rvalid_o,
   output logic [Width-1:0] d_rdata_o,
   output logic             stall_if_o,
   output logic             stall_mem_o,
   output logic             mem_en_o,
   output logic             mem_we_o,
   output logic [3:0]       mem_be_o,
   output logic [Width-1:0] mem_addr_o,
   output logic [Width-1:0] mem_wdata_o,
   input  logic [Width-1:0] mem_rdata_i
);

   localparam int CntW = $clog2(StarveLimit + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RSP_IF = 2'd1,
      RSP_D  = 2'd2
   } rsp_e;

   rsp_e            rsp_q;
   logic [CntW-1:0] starve_cnt;
   logic            fetch_first;

   assign fetch_first = (starve_cnt == CntW'(StarveLimit));
   assign if_gnt_o    = if_req_i & (~d_req_i | fetch_first);
   assign d_gnt_o     = d_req_i & ~if_gnt_o;
   assign stall_if_o  = if_req_i & ~if_gnt_o;
   assign stall_mem_o = d_req_i & ~d_gnt_o;

   // Reads always present full byte enables; write data is only driven for stores.
   always_comb begin
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'h0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (if_gnt_o) begin
         mem_en_o   = 1'b1;
         mem_be_o   = 4'hf;
         mem_addr_o = if_addr_i;
      end else if (d_gnt_o) begin
         mem_en_o    = 1'b1;
         mem_we_o    = d_we_i;
         mem_be_o    = d_we_i ? d_be_i : 4'hf;
         mem_addr_o  = d_addr_i;
         mem_wdata_o = d_we_i ? d_wdata_i : '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_q <= IDLE;
      end else if (if_gnt_o) begin
         rsp_q <= RSP_IF;
      end else if (d_gnt_o && !d_we_i) begin
         rsp_q <= RSP_D;
      end else begin
         rsp_q <= IDLE;
      end
   end

   // Counts data grants that overtook a waiting fetch; saturates rather than wraps.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         starve_cnt <= '0;
      end else if (if_gnt_o || !if_req_i) begin
         starve_cnt <= '0;
      end else if (d_gnt_o && !fetch_first) begin
         starve_cnt <= starve_cnt + CntW'(1);
      end
   end

   assign if_rvalid_o = (rsp_q == RSP_IF);
   assign d_rvalid_o  = (rsp_q == RSP_D);
   assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
   assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a cycle-level reference model.
module tb_mem_port_arbiter;

   localparam int LIM = 4;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_gnt_o, if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        d_req_i, d_we_i;
   logic [3:0]  d_be_i;
   logic [31:0] d_addr_i, d_wdata_i;
   logic        d_gnt_o, d_rvalid_o;
   logic [31:0] d_rdata_o;
   logic        stall_if_o, stall_mem_o;
   logic        mem_en_o, mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

   mem_port_arbiter #(.Width(32), .StarveLimit(LIM)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
      .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
      .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   // Reference model: data grants that jumped ahead of a waiting fetch, and the response owed next cycle.
   int wait_cnt = 0;
   int exp_rsp  = 0;   // 0 none, 1 fetch, 2 load
   int last_g   = 0;   // 0 none, 1 fetch, 2 data

   logic        r_ir, r_dr, r_dw;
   logic [31:0] r_ia, r_da, r_dwd;
   logic [3:0]  r_dbe;
   int          pat [10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                        input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dwd,
                        input logic [31:0] rd);
      logic eg_if, eg_d;
      logic [3:0] e_be;
      logic [31:0] e_addr;
      @(negedge clk);
      if_req_i = ir; if_addr_i = ia;
      d_req_i = dr; d_we_i = dw; d_be_i = dbe; d_addr_i = da; d_wdata_i = dwd;
      mem_rdata_i = rd;
      #1;
      eg_if  = ir && (!dr || wait_cnt >= LIM);
      eg_d   = dr && !eg_if;
      e_be   = eg_if ? 4'hf : (eg_d ? (dw ? dbe : 4'hf) : 4'h0);
      e_addr = eg_if ? ia : (eg_d ? da : 32'h0);
      chk("if_gnt", 32'(if_gnt_o), 32'(eg_if));
      chk("d_gnt", 32'(d_gnt_o), 32'(eg_d));
      chk("stall_if", 32'(stall_if_o), 32'(ir && !eg_if));
      chk("stall_mem", 32'(stall_mem_o), 32'(dr && !eg_d));
      chk("mem_en", 32'(mem_en_o), 32'(eg_if || eg_d));
      chk("mem_we", 32'(mem_we_o), 32'(eg_d && dw));
      chk("mem_be", 32'(mem_be_o), 32'(e_be));
      chk("mem_addr", mem_addr_o, e_addr);
      chk("mem_wdata", mem_wdata_o, (eg_d && dw) ? dwd : 32'h0);
      chk("if_rvalid", 32'(if_rvalid_o), 32'(exp_rsp == 1));
      chk("d_rvalid", 32'(d_rvalid_o), 32'(exp_rsp == 2));
      chk("if_rdata", if_rdata_o, (exp_rsp == 1) ? rd : 32'h0);
      chk("d_rdata", d_rdata_o, (exp_rsp == 2) ? rd : 32'h0);
      last_g = eg_if ? 1 : (eg_d ? 2 : 0);
      @(posedge clk);
      exp_rsp = eg_if ? 1 : ((eg_d && !dw) ? 2 : 0);
      if (eg_if || !ir) wait_cnt = 0;
      else if (eg_d && wait_cnt < LIM) wait_cnt++;
   endtask

   task automatic idle(input logic [31:0] rd);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, rd);
   endtask

   initial begin
      rst_ni = 1'b0;
      if_req_i = 1'b0; if_addr_i = '0; d_req_i = 1'b0; d_we_i = 1'b0;
      d_be_i = '0; d_addr_i = '0; d_wdata_i = '0; mem_rdata_i = 32'h1234_5678;
      #1;
      chk("rst_if_rvalid", 32'(if_rvalid_o), 32'h0);
      chk("rst_d_rvalid", 32'(d_rvalid_o), 32'h0);
      chk("rst_if_rdata", if_rdata_o, 32'h0);
      chk("rst_d_rdata", d_rdata_o, 32'h0);
      chk("rst_mem_en", 32'(mem_en_o), 32'h0);
      chk("rst_gnt", 32'({if_gnt_o, d_gnt_o, stall_if_o, stall_mem_o}), 32'h0);
      @(negedge clk);
      rst_ni = 1'b1;

      // Fetch-only read at 0x10
      cycle(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
      idle(32'h0050_0093);

      // Fetch and load together with an empty starvation count
      cycle(1'b1, 32'h20, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 32'h0);
      chk("sim_first_gnt", 32'(last_g), 32'd2);
      cycle(1'b1, 32'h20, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hAAAA_0001);
      chk("sim_second_gnt", 32'(last_g), 32'd1);
      idle(32'hBBBB_0002);

      // Continuous contention: fetch gets through every fifth cycle
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 32'h40, 1'b1, 1'b0, 4'h0, 32'h300 + 32'(i * 4), 32'h0, $urandom);
         chk("gseq", 32'(last_g), 32'(pat[i]));
      end
      idle($urandom);

      // Store: no response follows
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h204, 32'hDEAD_BEEF, 32'h0);
      idle(32'h5555_5555);

      // Back-to-back fetches
      cycle(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
      cycle(1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h1000_0000);
      cycle(1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h1000_0004);
      idle(32'h1000_0008);
      idle($urandom);

      // Build up the starvation count, leave a load outstanding, then reset mid-cycle
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 32'h80, 1'b1, 1'b0, 4'h0, 32'h400, 32'h0, $urandom);
      #2;
      rst_ni = 1'b0;
      if_req_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0;
      mem_rdata_i = 32'hCAFE_F00D;
      #1;
      chk("midrst_d_rvalid", 32'(d_rvalid_o), 32'h0);
      chk("midrst_d_rdata", d_rdata_o, 32'h0);
      chk("midrst_if_rvalid", 32'(if_rvalid_o), 32'h0);
      chk("midrst_mem_en", 32'(mem_en_o), 32'h0);
      wait_cnt = 0;
      exp_rsp = 0;
      @(negedge clk);
      rst_ni = 1'b1;
      idle(32'hCAFE_F00D);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 32'h80, 1'b1, 1'b0, 4'h0, 32'h400, 32'h0, $urandom);
         chk("post_rst_gseq", 32'(last_g), 32'(pat[i]));
      end
      idle($urandom);

      // Randomized traffic; requesters hold their request until granted
      r_ir = 1'b0; r_dr = 1'b0; r_dw = 1'b0;
      r_ia = '0; r_da = '0; r_dwd = '0; r_dbe = '0;
      for (int i = 0; i < 400; i++) begin
         if (!r_ir) begin
            r_ir = ($urandom_range(0, 3) != 0);
            r_ia = $urandom & 32'hffff_fffc;
         end
         if (!r_dr) begin
            r_dr  = ($urandom_range(0, 3) != 0);
            r_dw  = 1'($urandom_range(0, 1));
            r_dbe = 4'($urandom);
            r_da  = $urandom;
            r_dwd = r_dw ? $urandom : 32'h0;
         end
         cycle(r_ir, r_ia, r_dr, r_dw, r_dbe, r_da, r_dwd, $urandom);
         if (last_g == 1) r_ir = 1'b0;
         if (last_g == 2) r_dr = 1'b0;
      end
      idle($urandom);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage LSU) of the 5-stage pipeline. It grants at most one access per cycle and returns read data one cycle later, tagged back to the winning requester. A bounded-starvation counter prevents continuous load/store traffic from locking out fetch. The pipeline uses the grant signals to drive its stall logic.

## Interface
- Width, 32, data and address width
- StarveLimit, 4, maximum consecutive data grants while fetch is waiting; legal range ≥1

- clk_i  in  1  clock; all state updates on posedge
- rst_ni  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch read request
- if_addr_i  in  Width  fetch byte address
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch read data valid
- if_rdata_o  out  Width  fetch read data; 0 when if_rvalid_o=0
- d_req_i  in  1  data request
- d_we_i  in  1  1=store, 0=load
- d_be_i  in  4  store byte enables
- d_addr_i  in  Width  data byte address
- d_wdata_i  in  Width  store data
- d_gnt_o  out  1  data request accepted this cycle
- d_rvalid_o  out  1  load data valid; never asserted for stores
- d_rdata_o  out  Width  load data; 0 when d_rvalid_o=0
- stall_if_o  out  1  if_req_i & ~if_gnt_o
- stall_mem_o  out  1  d_req_i & ~d_gnt_o
- mem_en_o  out  1  memory access this cycle
- mem_we_o  out  1  memory write
- mem_be_o  out  4  memory byte enables (4'b1111 on reads)
- mem_addr_o  out  Width  memory address
- mem_wdata_o  out  Width  memory write data
- mem_rdata_i  in  Width  memory read data, valid the cycle after a read is issued

## Operation
- Grant is combinational from the requests. Requesters hold req/addr/data stable until they see gnt. req must not depend combinationally on gnt.
- Priority: data wins by default because it belongs to the older instruction. Fetch wins when starve_cnt == StarveLimit and if_req_i=1.
- Granted requester's fields drive mem_*. With no grant: mem_en_o=0 and the other mem_* outputs are 0.
- starve_cnt (width $clog2(StarveLimit+1)):
  - increments when d_gnt_o & if_req_i;
  - clears when if_gnt_o or when if_req_i=0;
  - saturates at StarveLimit, never wraps.
- Response FSM, state register rsp_q:
  - IDLE: no read outstanding.
  - RSP_IF: fetch read issued last cycle. if_rvalid_o=1 and if_rdata_o=mem_rdata_i.
  - RSP_D: data load issued last cycle. d_rvalid_o=1 and d_rdata_o=mem_rdata_i.
- Next state, from any state:
  - granted fetch → RSP_IF;
  - granted load → RSP_D;
  - granted store or no grant → IDLE.
- A new grant is legal in every state, so back-to-back accesses run at full throughput and a response and a new issue overlap.
- Stores complete at the clock edge where d_gnt_o=1. They produce no response.
- Address and be checks are not performed here; alignment is the LSU's responsibility.

## Timing
- Reset values: rsp_q=IDLE, starve_cnt=0. All outputs 0, because rvalid=0 and there are no requests.
- Grant latency: 0 cycles (same cycle as req). Read data latency: exactly 1 cycle after grant.
- Simultaneous requests with starve_cnt<StarveLimit: data granted, fetch stalls that cycle.
- Simultaneous requests with starve_cnt==StarveLimit: fetch granted, data stalls one cycle, counter clears.
- A read response and a new grant in the same cycle are independent. rvalid always reflects the previous cycle's grant.
- Reset asserted mid-operation: any pending response is discarded and rvalid drops immediately (asynchronous). After rst_ni rises, no stale rvalid appears.
- Requests present in the first cycle after reset release are granted normally.
- At most one rvalid (IF or D) is high in any cycle.

## Test plan
- Fetch-only read at 0x10, memory returns 0x00500093 → if_gnt_o=1 and mem_addr_o=0x10 same cycle. Next cycle: if_rvalid_o=1, if_rdata_o=0x00500093, d_rvalid_o=0.
- Fetch and load at 0x100 asserted together, starve_cnt=0 → cycle0: d_gnt=1, stall_if_o=1. Cycle1: if_gnt=1, d_rvalid=1. Cycle2: if_rvalid=1.
- Both requesting continuously, StarveLimit=4 → grant sequence D,D,D,D,IF,D,D,D,D,IF. starve_cnt never exceeds 4.
- Store d_addr=0x204, d_be=4'b0011, d_wdata=0xDEADBEEF → same cycle: mem_en=1, mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF. Next cycle: d_rvalid=0.
- Fetch reads every cycle at 0x0, 0x4, 0x8 → if_gnt high each cycle, if_rvalid high for three consecutive cycles, data returned in order.
- Load granted, then rst_ni low mid-cycle before the response → d_rvalid_o and all outputs 0 immediately. No rvalid after release. starve_cnt=0.
